// File: rtl/dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : dot_matrix_scanner
//  Purpose  : Row-multiplexed driver for an 8x8 LED dot matrix. It takes a
//             single-cycle snapshot of the 64-bit game map word at the start
//             of each frame, so a frame never tears. It drives each row for
//             ROW_DIV cycles and then blanks for BLANK_CYCLES cycles to
//             suppress ghosting.
//  Ports    : i_Clk         system clock
//             i_Rst         asynchronous active-high reset
//             i_Map_Data    map word, row r = bits [8r+7:8r], col c = bit c
//             i_Enable      scan enable (level)
//             i_Test        lamp test (level); latched frames show all-on
//             o_Row         one-hot row select, active-high
//             o_Col         column data of the selected row, active-high
//             o_Row_Idx     index of the row being driven or blanked
//             o_Frame_Sync  pulse on the first drive cycle of row 0
//  Revision : 1.0  initial release
// ============================================================================
module dot_matrix_scanner #(
  parameter int unsigned ROW_DIV      = 6000,
  parameter int unsigned BLANK_CYCLES = 250,
  parameter bit          COL_REVERSE  = 1'b0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [63:0] i_Map_Data,
  input  logic        i_Enable,
  input  logic        i_Test,
  output logic [7:0]  o_Row,
  output logic [7:0]  o_Col,
  output logic [2:0]  o_Row_Idx,
  output logic        o_Frame_Sync
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_BLANK = 2'd3;

  // Counters run 0..N-1, so compare against the last value.
  localparam logic [15:0] c_ROW_LAST   = 16'(ROW_DIV - 1);
  localparam logic [15:0] c_BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [2:0]  c_LAST_ROW   = 3'd7;

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [63:0] r_snapshot;
  logic [2:0]  r_row_idx;
  logic [7:0]  r_row;
  logic [7:0]  r_col;
  logic        r_frame_sync;

  logic [1:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [63:0] w_snapshot_nxt;
  logic [2:0]  w_row_idx_nxt;
  logic [7:0]  w_row_nxt;
  logic [7:0]  w_col_nxt;
  logic        w_sync_nxt;

  logic [63:0] w_fresh_word;
  logic [63:0] w_src_word;
  logic [2:0]  w_src_idx;
  logic [7:0]  w_col_raw;
  logic [7:0]  w_col_ordered;

  // Value captured by the snapshot; lamp test overrides the map entirely.
  assign w_fresh_word = i_Test ? 64'hFFFF_FFFF_FFFF_FFFF : i_Map_Data;

  // Outputs are registered, so the column byte for a row has to be ready on
  // the edge that enters S_DRIVE. Leaving S_LATCH, the snapshot register is
  // not loaded yet, so row 0 is taken straight from the fresh word. Leaving
  // S_BLANK, the next row comes from the stored snapshot.
  assign w_src_word = (r_state == S_LATCH) ? w_fresh_word : r_snapshot;
  assign w_src_idx  = (r_state == S_LATCH) ? 3'd0 : (r_row_idx + 3'd1);
  assign w_col_raw  = w_src_word[{w_src_idx, 3'b000} +: 8];

  generate
    if (COL_REVERSE) begin : g_col_rev
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign w_col_ordered[gi] = w_col_raw[7-gi];
      end
    end else begin : g_col_fwd
      assign w_col_ordered = w_col_raw;
    end
  endgenerate

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_snapshot_nxt = r_snapshot;
    w_row_idx_nxt  = r_row_idx;
    w_row_nxt      = 8'd0;
    w_col_nxt      = 8'd0;
    w_sync_nxt     = 1'b0;

    if ((r_state != S_IDLE) && !i_Enable) begin
      // Abandon the partial frame; the next enable restarts from a snapshot.
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = 16'd0;
      w_row_idx_nxt = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_Enable) begin
            w_state_nxt = S_LATCH;
            w_cnt_nxt   = 16'd0;
          end
        end

        S_LATCH: begin
          w_snapshot_nxt = w_fresh_word;
          w_row_idx_nxt  = 3'd0;
          w_cnt_nxt      = 16'd0;
          w_state_nxt    = S_DRIVE;
          w_row_nxt      = 8'd1;
          w_col_nxt      = w_col_ordered;
          w_sync_nxt     = 1'b1;
        end

        S_DRIVE: begin
          if (r_cnt == c_ROW_LAST) begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = S_BLANK;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
            w_row_nxt = r_row;
            w_col_nxt = r_col;
          end
        end

        S_BLANK: begin
          if (r_cnt == c_BLANK_LAST) begin
            w_cnt_nxt = 16'd0;
            if (r_row_idx != c_LAST_ROW) begin
              w_row_idx_nxt = w_src_idx;
              w_state_nxt   = S_DRIVE;
              w_row_nxt     = 8'd1 << w_src_idx;
              w_col_nxt     = w_col_ordered;
            end else begin
              // Enable is known high here; a low enable took the branch above.
              w_state_nxt = S_LATCH;
            end
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_snapshot   <= 64'd0;
      r_row_idx    <= 3'd0;
      r_row        <= 8'd0;
      r_col        <= 8'd0;
      r_frame_sync <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_snapshot   <= w_snapshot_nxt;
      r_row_idx    <= w_row_idx_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_frame_sync <= w_sync_nxt;
    end
  end

  assign o_Row        = r_row;
  assign o_Col        = r_col;
  assign o_Row_Idx    = r_row_idx;
  assign o_Frame_Sync = r_frame_sync;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dot_matrix_scanner
//  Purpose  : Self-checking bench for dot_matrix_scanner with ROW_DIV=4 and
//             BLANK_CYCLES=2 (49-cycle frame). A normal instance and a
//             column-mirrored instance share all inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dot_matrix_scanner;

  localparam int ROW_DIV  = 4;
  localparam int BLANK    = 2;
  localparam int ROW_SPAN = ROW_DIV + BLANK;
  localparam int FRAME    = 1 + 8 * ROW_SPAN;
  localparam int NVEC     = 6;

  typedef struct {
    logic [63:0] map;
    logic        test;
    logic [63:0] exp;
  } frame_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        tst = 1'b0;
  logic [63:0] map = 64'd0;

  logic [7:0]  row, col, row_m, col_m;
  logic [2:0]  idx, idx_m;
  logic        sync, sync_m;

  int checks = 0;
  int errors = 0;

  frame_vec_t vecs [NVEC];

  always #5 clk = ~clk;

  dot_matrix_scanner #(
    .ROW_DIV(ROW_DIV), .BLANK_CYCLES(BLANK), .COL_REVERSE(1'b0)
  ) u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_Map_Data(map), .i_Enable(en), .i_Test(tst),
    .o_Row(row), .o_Col(col), .o_Row_Idx(idx), .o_Frame_Sync(sync)
  );

  dot_matrix_scanner #(
    .ROW_DIV(ROW_DIV), .BLANK_CYCLES(BLANK), .COL_REVERSE(1'b1)
  ) u_dut_mirror (
    .i_Clk(clk), .i_Rst(rst), .i_Map_Data(map), .i_Enable(en), .i_Test(tst),
    .o_Row(row_m), .o_Col(col_m), .o_Row_Idx(idx_m), .o_Frame_Sync(sync_m)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Expected outputs at position p of a frame (p=0 is the sync cycle,
  // p=FRAME-1 is the latch cycle of the following frame).
  task automatic check_cycle(input int p, input logic [63:0] exp_word);
    int         rn;
    logic [7:0] e_row, e_col;
    if (p == FRAME - 1) begin
      check("latch_row", 64'(row), 64'd0);
      check("latch_col", 64'(col), 64'd0);
      check("latch_sync", 64'(sync), 64'd0);
      check("latch_col_m", 64'(col_m), 64'd0);
    end else begin
      rn = p / ROW_SPAN;
      if ((p % ROW_SPAN) < ROW_DIV) begin
        e_row = 8'(1 << rn);
        e_col = exp_word[8*rn +: 8];
      end else begin
        e_row = 8'd0;
        e_col = 8'd0;
      end
      check("row", 64'(row), 64'(e_row));
      check("col", 64'(col), 64'(e_col));
      check("row_idx", 64'(idx), 64'(rn));
      check("frame_sync", 64'(sync), 64'(p == 0));
      check("row_m", 64'(row_m), 64'(e_row));
      check("col_m", 64'(col_m), 64'(rev8(e_col)));
    end
  endtask

  // Called at the sync cycle; returns at the next frame's sync cycle.
  // The next frame's inputs are applied at the start of row 3.
  task automatic run_frame(input logic [63:0] exp_word, input logic [63:0] nmap, input logic ntest);
    for (int p = 0; p < FRAME; p++) begin
      check_cycle(p, exp_word);
      if (p == 3 * ROW_SPAN) begin
        map = nmap;
        tst = ntest;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] rnd;
    rnd = {$urandom, $urandom};

    vecs[0] = '{rnd,                    1'b0, rnd};
    vecs[1] = '{64'h8040_2010_0804_0201, 1'b0, 64'h8040_2010_0804_0201};
    vecs[2] = '{64'h0,                   1'b0, 64'h0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{64'h0000_0000_0000_0003, 1'b0, 64'h0000_0000_0000_0003};

    // Reset held with enable high and a random map.
    map = rnd;
    en  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_row", 64'(row), 64'd0);
    check("rst_col", 64'(col), 64'd0);
    check("rst_idx", 64'(idx), 64'd0);
    check("rst_sync", 64'(sync), 64'd0);
    check("rst_col_m", 64'(col_m), 64'd0);

    rst = 1'b0;
    @(negedge clk);                       // latch cycle
    check("post_rst_latch_sync", 64'(sync), 64'd0);
    check("post_rst_latch_row", 64'(row), 64'd0);
    @(negedge clk);                       // first drive of row 0

    // Row walk, snapshot, lamp test, restore and mirror frames.
    for (int k = 0; k < NVEC; k++) begin
      int nk;
      nk = (k < NVEC - 1) ? k + 1 : NVEC - 1;
      run_frame(vecs[k].exp, vecs[nk].map, vecs[nk].test);
    end

    // Mirror: row-0 byte 03 appears reversed as C0.
    check("mirror_row", 64'(row_m), 64'h01);
    check("mirror_col", 64'(col_m), 64'hC0);

    // Enable drop during the drive of row 5.
    for (int p = 0; p < 5 * ROW_SPAN + 1; p++) begin
      check_cycle(p, vecs[5].exp);
      @(negedge clk);
    end
    check("pre_drop_row", 64'(row), 64'h20);
    en = 1'b0;
    @(negedge clk);
    check("drop_row", 64'(row), 64'd0);
    check("drop_col", 64'(col), 64'd0);
    check("drop_sync", 64'(sync), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_row", 64'(row), 64'd0);
      check("idle_col", 64'(col), 64'd0);
      check("idle_sync", 64'(sync), 64'd0);
    end
    en = 1'b1;
    @(negedge clk);
    check("reen_latch_sync", 64'(sync), 64'd0);
    check("reen_latch_row", 64'(row), 64'd0);
    @(negedge clk);
    run_frame(vecs[5].exp, vecs[5].map, vecs[5].test);

    // Asynchronous reset in the middle of row 1's drive.
    for (int p = 0; p < ROW_SPAN + 2; p++) begin
      check_cycle(p, vecs[5].exp);
      @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    check("async_rst_row", 64'(row), 64'd0);
    check("async_rst_idx", 64'(idx), 64'd0);
    check("async_rst_sync", 64'(sync), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerst_latch_sync", 64'(sync), 64'd0);
    @(negedge clk);
    run_frame(vecs[5].exp, vecs[5].map, vecs[5].test);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
Reader side of the game-logic map interface. Takes the 64-bit map word that game logic produces and drives the 8x8 dot-matrix by row-multiplexing. Each frame starts from a single-cycle snapshot, so the display never tears. Each row is followed by a blanking gap to stop ghosting. Sits between game logic and the board's matrix row/column pins.

Parameters:
ROW_DIV, 6000, clock cycles each row is driven (1..65535)
BLANK_CYCLES, 250, clock cycles of all-off between rows (1..65535)
COL_REVERSE, 0, 1 = mirror column order within each row

Ports:
i_Clk  input  1  system clock, 50 MHz
i_Rst  input  1  asynchronous, active-high reset
i_Map_Data  input  64  map word; row r = bits [8r+7:8r], row 0 = judgement row; column c = bit c of the row byte
i_Enable  input  1  scan enable, level
i_Test  input  1  lamp test, level; frames latched while high show all LEDs on
o_Row  output  8  one-hot row select, active-high
o_Col  output  8  column data for the selected row, active-high
o_Row_Idx  output  3  index of the row currently driven or blanked
o_Frame_Sync  output  1  one-cycle pulse on the first drive cycle of row 0

Behaviour:
- All outputs are registered. Reset (async, i_Rst=1) forces:
  - o_Row=0, o_Col=0, o_Row_Idx=0, o_Frame_Sync=0
  - snapshot=0, row/blank counters=0, state=S_IDLE
- States: S_IDLE, S_LATCH, S_DRIVE, S_BLANK.
- S_IDLE:
  - o_Row=0, o_Col=0.
  - i_Enable=1 sampled -> S_LATCH next cycle.
- S_LATCH (exactly 1 cycle):
  - snapshot <= i_Test ? 64'hFFFF_FFFF_FFFF_FFFF : i_Map_Data.
  - row index <= 0.
  - -> S_DRIVE.
- S_DRIVE:
  - o_Row = 8'b1 << row_idx.
  - o_Col = snapshot byte of row_idx, bit-reversed if COL_REVERSE=1.
  - Held for exactly ROW_DIV cycles, then -> S_BLANK.
- S_BLANK:
  - o_Row=0, o_Col=0 for exactly BLANK_CYCLES cycles.
  - At the end, if row_idx<7: row_idx+1 -> S_DRIVE.
  - If row_idx==7: -> S_LATCH when i_Enable=1, else -> S_IDLE.
- Latency: the first drive cycle of row 0 is 2 cycles after i_Enable is first sampled high in S_IDLE.
- Frame period = 1 + 8*(ROW_DIV+BLANK_CYCLES) cycles. With defaults this is 50001 cycles, about 1 kHz at 50 MHz.
- o_Frame_Sync is high only on the first S_DRIVE cycle of row 0, once per frame.
- Snapshot rule: changes to i_Map_Data or i_Test mid-frame have no visible effect until the next S_LATCH.
- i_Enable=0 sampled in any non-idle state:
  - -> S_IDLE next cycle, with o_Row=0 and o_Col=0 on that same next cycle.
  - The partial frame is abandoned.
  - Re-enabling always restarts at S_LATCH / row 0.
- o_Row is never non-zero in two consecutive rows without at least BLANK_CYCLES zero cycles between them. At most one o_Row bit is high at any time.
- Counters are 16 bits and count 0..N-1. Counter and row index wrap only via the state transitions above, never by overflow.
- Reset asserted mid-operation: all outputs clear asynchronously. After release, behaviour is as from power-up.

Test Plan:
(All cases use ROW_DIV=4 and BLANK_CYCLES=2, so frame = 49 cycles.)
- Reset:
  - Stimulus: hold i_Rst=1 with i_Enable=1 and a random map.
  - Required: o_Row=0, o_Col=0, o_Row_Idx=0, o_Frame_Sync=0. After release, first o_Frame_Sync is 2 cycles after i_Enable is sampled.
- Row walk:
  - Stimulus: i_Map_Data=64'h8040_2010_0804_0201, i_Enable=1.
  - Required: row r shows o_Row=1<<r and o_Col=1<<r for 4 cycles, then 2 zero cycles. o_Frame_Sync pulses every 49 cycles.
- Snapshot:
  - Stimulus: change i_Map_Data to 64'h0 during row 3.
  - Required: rows 3..7 of the current frame still show old data. The next frame shows all o_Col=0.
- Lamp test:
  - Stimulus: raise i_Test mid-frame.
  - Required: the current frame is unchanged. The next frame has o_Col=8'hFF on every row. Lowering i_Test restores the map on the following frame.
- Enable drop:
  - Stimulus: deassert i_Enable during the drive of row 5.
  - Required: o_Row=0 and o_Col=0 on the next cycle and the block stays idle. On re-enable, o_Row_Idx=0 and o_Frame_Sync fires 2 cycles later.
- Mirror:
  - Stimulus: COL_REVERSE=1, row-0 byte 8'h03.
  - Required: o_Col=8'hC0 while o_Row=8'h01.
